// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: control-field selects,
// ALU-control codes, funct values and opcodes.
package mc_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD     = 2'b00,
    ALUOP_SUB     = 2'b01,
    ALUOP_FUNCT   = 2'b10,
    ALUOP_ADD_ALT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctl_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Sign-extend a 16-bit immediate by replicating its top bit.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_if.sv
// Control word, unified-memory and register-file bus of the datapath.
// master: control FSM / memory / register-file side; slave: the datapath.
interface mc_if;
  logic        pc_w;
  logic        pc_wc;
  logic [1:0]  pc_src;
  logic        pc_res;
  logic        mem_r;
  logic        mem_w;
  logic        ireg_w;
  logic        regdst;
  logic        reg_w;
  logic        memtoreg;
  logic        alu_srca;
  logic [1:0]  alu_srcb;
  logic [1:0]  alu_op;

  logic [5:0]  op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;

  modport master (
    output pc_w, pc_wc, pc_src, pc_res, mem_r, mem_w, ireg_w, regdst, reg_w,
           memtoreg, alu_srca, alu_srcb, alu_op, mem_rdata, rf_rdata1, rf_rdata2,
    input  op, mem_addr, mem_wdata, mem_re, mem_we, rf_raddr1, rf_raddr2,
           rf_waddr, rf_wdata, rf_we
  );

  modport slave (
    input  pc_w, pc_wc, pc_src, pc_res, mem_r, mem_w, ireg_w, regdst, reg_w,
           memtoreg, alu_srca, alu_srcb, alu_op, mem_rdata, rf_rdata1, rf_rdata2,
    output op, mem_addr, mem_wdata, mem_re, mem_we, rf_raddr1, rf_raddr2,
           rf_waddr, rf_wdata, rf_we
  );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU-control decode plus 32-bit ALU with zero flag.
module mc_alu
  import mc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  output logic [31:0] result,
  output logic        zero
);

  alu_ctl_e ctl;

  // Map alu_op (and funct for R-type) to an internal ALU operation.
  always_comb begin
    ctl = ALU_ADD;
    case (alu_op_e'(alu_op))
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctl = ALU_ADD;
          FUNCT_SUB: ctl = ALU_SUB;
          FUNCT_AND: ctl = ALU_AND;
          FUNCT_OR:  ctl = ALU_OR;
          FUNCT_NOR: ctl = ALU_NOR;
          FUNCT_SLT: ctl = ALU_SLT;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
  end

  // Evaluate the selected operation; arithmetic wraps modulo 2^32.
  always_comb begin
    result = '0;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
      ALU_NOR: result = ~(a | b);
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, operand/next-PC
// muxes and the ALU, driven by one control word per cycle.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  mc_if.slave bus
);

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;

  logic [31:0] imm_ext;
  logic [31:0] jump_target;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] next_pc;
  logic        pc_load;

  assign imm_ext     = sext16(ir[15:0]);
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};

  // ALU A operand: PC or the A register.
  always_comb begin
    alu_a = bus.alu_srca ? a_reg : pc;
  end

  // ALU B operand: B, constant 4, sign-extended immediate, or word offset.
  always_comb begin
    alu_b = b_reg;
    case (alu_srcb_e'(bus.alu_srcb))
      SRCB_B:       alu_b = b_reg;
      SRCB_FOUR:    alu_b = 32'd4;
      SRCB_IMM:     alu_b = imm_ext;
      SRCB_IMM_SH2: alu_b = {imm_ext[29:0], 2'b00};
    endcase
  end

  mc_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (bus.alu_op),
    .funct  (ir[5:0]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next-PC select; HOLD recirculates the current PC so a write is a no-op.
  always_comb begin
    next_pc = pc;
    case (pc_src_e'(bus.pc_src))
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = jump_target;
      PCSRC_HOLD:   next_pc = pc;
    endcase
  end

  assign pc_load = bus.pc_w | (bus.pc_wc & alu_zero);

  // Architectural PC and IR: enabled loads, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (pc_load)    pc <= next_pc;
      if (bus.ireg_w) ir <= bus.mem_rdata;
    end
  end

  // Inter-cycle registers: capture every cycle, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= bus.mem_rdata;
      a_reg   <= bus.rf_rdata1;
      b_reg   <= bus.rf_rdata2;
      alu_out <= alu_result;
    end
  end

  assign bus.op        = ir[31:26];
  assign bus.mem_addr  = bus.pc_res ? alu_out : pc;
  assign bus.mem_wdata = b_reg;
  assign bus.mem_re    = bus.mem_r;
  assign bus.mem_we    = bus.mem_w;
  assign bus.rf_raddr1 = ir[25:21];
  assign bus.rf_raddr2 = ir[20:16];
  assign bus.rf_waddr  = bus.regdst ? ir[15:11] : ir[20:16];
  assign bus.rf_wdata  = bus.memtoreg ? mdr : alu_out;
  assign bus.rf_we     = bus.reg_w;

endmodule
